// File: rtl/ul4_drv_if.sv
// Request, ul4 drive/sample and response signals for the ul4 sequencer.
// master is the sequencer side; slave is the requester/ul4/consumer side.
interface ul4_drv_if #(
    parameter int W = 4
);
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [1:0]   req_s;

    logic [W-1:0] ul_a;
    logic [W-1:0] ul_b;
    logic [1:0]   ul_s;
    logic [W-1:0] ul_out;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_out;
    logic [1:0]   rsp_s;

    modport master (
        input  req_valid, req_a, req_b, req_s, ul_out, rsp_ready,
        output req_ready, ul_a, ul_b, ul_s, rsp_valid, rsp_out, rsp_s
    );

    modport slave (
        output req_valid, req_a, req_b, req_s, ul_out, rsp_ready,
        input  req_ready, ul_a, ul_b, ul_s, rsp_valid, rsp_out, rsp_s
    );
endinterface

// File: rtl/ul4_drv.sv
// Sequential initiator for the ul4 logic unit: queues requests, drives one
// operand set per operation, samples the unit output and returns it in order.
module ul4_drv #(
    parameter int W     = 4,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    ul4_drv_if.master     bus,
    output logic          busy,
    output logic [CW-1:0] op_count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int EW    = 2 * W + 2;

    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [W-1:0]     ul_a_q, ul_b_q, rsp_out_q;
    logic [1:0]       ul_s_q, rsp_s_q;
    logic [CW-1:0]    op_count_q;
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    head;

    logic full, empty, push, pop, capture, done;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.req_valid && !full;
    assign head  = mem[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                capture = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.rsp_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage needs no reset: occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {bus.req_s, bus.req_b, bus.req_a};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ul_a_q     <= '0;
            ul_b_q     <= '0;
            ul_s_q     <= '0;
            rsp_out_q  <= '0;
            rsp_s_q    <= '0;
            op_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                ul_a_q   <= head[W-1:0];
                ul_b_q   <= head[2*W-1:W];
                ul_s_q   <= head[EW-1:2*W];
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (capture) begin
                rsp_out_q <= bus.ul_out;
                rsp_s_q   <= ul_s_q;
            end
            if (done) begin
                op_count_q <= op_count_q + CW'(1);
            end
        end
    end

    assign bus.req_ready = !full;
    assign bus.ul_a      = ul_a_q;
    assign bus.ul_b      = ul_b_q;
    assign bus.ul_s      = ul_s_q;
    assign bus.rsp_valid = (state_q == HOLD);
    assign bus.rsp_out   = rsp_out_q;
    assign bus.rsp_s     = rsp_s_q;
    assign busy          = (state_q != IDLE) || !empty;
    assign op_count      = op_count_q;
endmodule
